// File: rtl/cc_msg_serializer_if.sv
// Byte-stream side and status of the cc message serializer.
// The slave modport is the serializer; the master modport is whoever feeds it and sinks bytes.
interface cc_msg_serializer_if #(
  parameter int unsigned MSG_W = 64
);
  logic [MSG_W-1:0] msg_in;
  logic             msg_valid;
  logic [7:0]       key_in;
  logic [7:0]       byte_out;
  logic             byte_valid;
  logic             byte_ready;
  logic             byte_last;
  logic             fifo_full;
  logic             fifo_empty;
  logic             overflow;
  logic [7:0]       msg_count;

  modport master (
    output msg_in, msg_valid, key_in, byte_ready,
    input  byte_out, byte_valid, byte_last, fifo_full, fifo_empty, overflow, msg_count
  );

  modport slave (
    input  msg_in, msg_valid, key_in, byte_ready,
    output byte_out, byte_valid, byte_last, fifo_full, fifo_empty, overflow, msg_count
  );
endinterface

// File: rtl/cc_msg_serializer.sv
// Buffers {key, message} pairs in a small FIFO and emits each message as MSG_W/8 bytes,
// MSB first, followed by one checksum byte (XOR of all message bytes and the key).
module cc_msg_serializer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned MSG_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  cc_msg_serializer_if.slave bus
);
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned NBYTES = MSG_W / 8;
  localparam int unsigned IDXW   = $clog2(NBYTES);
  localparam int unsigned EW     = MSG_W + 8;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, SEND, CSUM} state_t;

  state_t            state_q, state_d;
  logic [EW-1:0]     mem_q [DEPTH];
  logic [EW-1:0]     mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              fifo_full_q, fifo_full_d, fifo_empty_q, fifo_empty_d;
  logic              overflow_q, overflow_d;
  // Holds only the bytes not yet loaded into byte_out; the top byte goes straight to byte_out.
  logic [MSG_W-9:0]  shift_q, shift_d;
  logic [7:0]        csum_q, csum_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [7:0]        byte_out_q, byte_out_d;
  logic              byte_valid_q, byte_valid_d, byte_last_q, byte_last_d;
  logic [7:0]        msg_count_q, msg_count_d;

  logic [EW-1:0]     head;
  logic [7:0]        head_csum;
  logic              has_room, pop, push, drop, xfer;

  // FIFO bookkeeping, serializer FSM and checksum precompute
  always_comb begin
    state_d      = state_q;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    overflow_d   = overflow_q;
    shift_d      = shift_q;
    csum_d       = csum_q;
    idx_d        = idx_q;
    byte_out_d   = byte_out_q;
    byte_valid_d = byte_valid_q;
    byte_last_d  = byte_last_q;
    msg_count_d  = msg_count_q;

    head      = mem_q[rd_ptr_q];
    head_csum = head[MSG_W +: 8];
    for (int unsigned i = 0; i < NBYTES; i++) begin
      head_csum = head_csum ^ head[i*8 +: 8];
    end

    has_room = (count_q < (AW+1)'(DEPTH));
    pop      = ena && (state_q == IDLE) && (count_q != '0);
    xfer     = ena && byte_valid_q && bus.byte_ready;
    push     = ena && bus.msg_valid && (has_room || pop);
    drop     = ena && bus.msg_valid && !has_room && !pop;

    if (push) begin
      mem_d[wr_ptr_q] = {bus.key_in, bus.msg_in};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d      = count_q + (AW+1)'(push) - (AW+1)'(pop);
    fifo_full_d  = (count_d == (AW+1)'(DEPTH));
    fifo_empty_d = (count_d == '0);
    if (drop) begin
      overflow_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (pop) begin
          byte_out_d   = head[MSG_W-1 -: 8];
          shift_d      = head[MSG_W-9:0];
          csum_d       = head_csum;
          idx_d        = '0;
          byte_valid_d = 1'b1;
          state_d      = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          if (idx_q == LAST_IDX) begin
            byte_out_d  = csum_q;
            byte_last_d = 1'b1;
            state_d     = CSUM;
          end else begin
            byte_out_d = shift_q[MSG_W-9 -: 8];
            shift_d    = shift_q << 8;
            idx_d      = idx_q + 1'b1;
          end
        end
      end
      CSUM: begin
        if (xfer) begin
          byte_valid_d = 1'b0;
          byte_last_d  = 1'b0;
          msg_count_d  = msg_count_q + 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; synchronous active-low reset discards FIFO and any partial message
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      fifo_full_q  <= 1'b0;
      fifo_empty_q <= 1'b1;
      overflow_q   <= 1'b0;
      shift_q      <= '0;
      csum_q       <= '0;
      idx_q        <= '0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      byte_last_q  <= 1'b0;
      msg_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      fifo_full_q  <= fifo_full_d;
      fifo_empty_q <= fifo_empty_d;
      overflow_q   <= overflow_d;
      shift_q      <= shift_d;
      csum_q       <= csum_d;
      idx_q        <= idx_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      byte_last_q  <= byte_last_d;
      msg_count_q  <= msg_count_d;
    end
  end

  assign bus.byte_out   = byte_out_q;
  assign bus.byte_valid = byte_valid_q;
  assign bus.byte_last  = byte_last_q;
  assign bus.fifo_full  = fifo_full_q;
  assign bus.fifo_empty = fifo_empty_q;
  assign bus.overflow   = overflow_q;
  assign bus.msg_count  = msg_count_q;
endmodule

// File: tb/tb_cc_msg_serializer.sv
// Scoreboard bench for cc_msg_serializer: directed scenarios followed by random traffic.
module tb_cc_msg_serializer;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  logic ena;

  cc_msg_serializer_if #(.MSG_W(64)) bus ();

  cc_msg_serializer #(.DEPTH(DEPTH), .MSG_W(64)) dut (
    .clk (clk),
    .rst (rst_n),
    .ena (ena),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Reference model: FIFO occupancy, bytes left in the message on the wire, status flags.
  int         m_size;
  int         m_rem;
  logic       m_ovf;
  logic [7:0] m_cnt;
  bit         started;
  logic [8:0] sb [$];   // {last, byte} expected on the stream, in order

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each active edge, from the inputs the bench is driving
  always @(posedge clk) begin
    int         sz0;
    bit         pop;
    logic [7:0] cs;
    logic [7:0] b;
    if (!rst_n) begin
      started = 1'b1;
      m_size  = 0;
      m_rem   = 0;
      m_ovf   = 1'b0;
      m_cnt   = 8'd0;
      sb.delete();
    end else if (ena) begin
      sz0 = m_size;
      pop = (m_rem == 0) && (m_size > 0);
      if (m_rem > 0 && bus.byte_ready) begin
        m_rem--;
        if (m_rem == 0) m_cnt = m_cnt + 8'd1;
      end
      if (pop) begin
        m_size--;
        m_rem = 9;
      end
      if (bus.msg_valid) begin
        if (sz0 < DEPTH || pop) begin
          m_size++;
          cs = bus.key_in;
          for (int i = 0; i < 8; i++) begin
            b  = bus.msg_in[63 - 8*i -: 8];
            cs = cs ^ b;
            sb.push_back({1'b0, b});
          end
          sb.push_back({1'b1, cs});
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  end

  // Monitor: compare status every cycle and the presented byte against the scoreboard head
  always @(negedge clk) begin
    if (started) begin
      check("byte_valid", 64'(bus.byte_valid), 64'(m_rem > 0));
      check("fifo_full",  64'(bus.fifo_full),  64'(m_size == DEPTH));
      check("fifo_empty", 64'(bus.fifo_empty), 64'(m_size == 0));
      check("overflow",   64'(bus.overflow),   64'(m_ovf));
      check("msg_count",  64'(bus.msg_count),  64'(m_cnt));
      if (bus.byte_valid) begin
        if (sb.size() == 0) begin
          check("sb_underrun", 64'(sb.size()), 64'd1);
        end else begin
          check("byte_out",  64'(bus.byte_out),  64'(sb[0][7:0]));
          check("byte_last", 64'(bus.byte_last), 64'(sb[0][8]));
          if (bus.byte_ready && ena && rst_n) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic step(input logic r, input logic v, input logic [63:0] m, input logic [7:0] k,
                      input logic rdy, input logic e);
    rst_n          = r;
    bus.msg_valid  = v;
    bus.msg_in     = m;
    bus.key_in     = k;
    bus.byte_ready = rdy;
    ena            = e;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 64'd0, 8'd0, rdy, 1'b1);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 64'd0, 8'd0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 64'd0, 8'd0, 1'b0, 1'b1);
  endtask

  localparam logic [63:0] M1 = 64'h0123_4567_89AB_CDEF;

  initial begin
    logic [63:0] rm;
    checks  = 0;
    errors  = 0;
    started = 1'b0;
    do_reset();

    // 1: single message, sink always ready
    step(1'b1, 1'b1, M1, 8'h5A, 1'b1, 1'b1);
    idle(12, 1'b1);

    // 2: same message, ready toggling
    step(1'b1, 1'b1, M1, 8'h5A, 1'b1, 1'b1);
    for (int i = 0; i < 24; i++) step(1'b1, 1'b0, 64'd0, 8'd0, logic'(i % 2), 1'b1);
    idle(4, 1'b1);

    // 3: six back-to-back pushes into a stalled sink, sixth dropped
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, {$urandom, $urandom}, 8'($urandom), 1'b0, 1'b1);
    idle(55, 1'b1);

    // 4: fill, drain one message, push on the cycle the FSM pops the next
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, {$urandom, $urandom}, 8'($urandom), 1'b0, 1'b1);
    idle(9, 1'b1);
    step(1'b1, 1'b1, {$urandom, $urandom}, 8'($urandom), 1'b1, 1'b1);
    idle(50, 1'b1);

    // 5: clock enable low for 3 cycles after byte 3 while msg_valid pulses
    step(1'b1, 1'b1, M1, 8'h33, 1'b1, 1'b1);
    idle(4, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, {$urandom, $urandom}, 8'hEE, 1'b1, 1'b0);
    idle(12, 1'b1);

    // 6: reset mid-message, then a fresh message restarts at its MSB
    step(1'b1, 1'b1, M1, 8'h5A, 1'b1, 1'b1);
    idle(5, 1'b1);
    step(1'b0, 1'b0, 64'd0, 8'd0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 64'hFEDC_BA98_7654_3210, 8'hC3, 1'b1, 1'b1);
    idle(12, 1'b1);

    // Random traffic: light load, then heavy load to force drops, with rare resets
    for (int i = 0; i < 3000; i++) begin
      rm = {$urandom, $urandom};
      if (i < 1500)
        step(logic'($urandom_range(0, 299) != 0), logic'($urandom_range(0, 9) < 3), rm,
             8'($urandom), logic'($urandom_range(0, 9) < 7), logic'($urandom_range(0, 9) != 0));
      else
        step(logic'($urandom_range(0, 299) != 0), logic'($urandom_range(0, 9) < 6), rm,
             8'($urandom), logic'($urandom_range(0, 9) < 3), logic'($urandom_range(0, 9) != 0));
    end

    idle(80, 1'b1);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
